// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type and counter sizing for the keypad synchroniser.
package keypad_pkg;

    typedef enum logic [2:0] {IDLE, DEBOUNCE, HELD, REPEAT, RELEASE} kp_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// sync_chain: per-bit multi-flop synchroniser with asynchronous active-low reset to 0.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/keypad_sync_repeat.sv
// keypad_sync_repeat: synchronise and debounce an N-key bus, latch the highest pressed
// key and emit press / auto-repeat strobes.
module keypad_sync_repeat
    import keypad_pkg::*;
#(
    parameter int N_KEYS          = 20,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [N_KEYS-1:0]         in,
    input  logic                      repeat_en,
    output logic                      strobe,
    output logic [$clog2(N_KEYS)-1:0] keycode,
    output logic                      key_held,
    output logic                      is_repeat
);

    localparam int KW = $clog2(N_KEYS);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    logic [N_KEYS-1:0] sync_bus;
    logic              any;
    logic [KW-1:0]     code_now;

    kp_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] cand_q, cand_d;
    logic [KW-1:0] keycode_q, keycode_d;
    logic          strobe_q, strobe_d;
    logic          is_repeat_q, is_repeat_d;
    logic          key_held_q;

    sync_chain #(.WIDTH(N_KEYS), .STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d_i  (in),
        .q_o  (sync_bus)
    );

    assign any = |sync_bus;

    // Ascending scan so the highest set index wins.
    always_comb begin
        code_now = '0;
        for (int i = 0; i < N_KEYS; i++)
            if (sync_bus[i]) code_now = KW'(i);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        keycode_d   = keycode_q;
        strobe_d    = 1'b0;
        is_repeat_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = DEBOUNCE;
                    cand_d  = code_now;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (!any || code_now != cand_q) begin
                    state_d = IDLE;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = HELD;
                    keycode_d = cand_q;
                    strobe_d  = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD, REPEAT: begin
                if (!any) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (code_now != keycode_q) begin
                    state_d = DEBOUNCE;
                    cand_d  = code_now;
                    cnt_d   = '0;
                end else if (!repeat_en) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == ((state_q == HELD) ? RD_LAST : RP_LAST)) begin
                    state_d     = REPEAT;
                    strobe_d    = 1'b1;
                    is_repeat_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (any && code_now == keycode_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (any) begin
                    state_d = DEBOUNCE;
                    cand_d  = code_now;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            keycode_q   <= '0;
            strobe_q    <= 1'b0;
            is_repeat_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            keycode_q   <= keycode_d;
            strobe_q    <= strobe_d;
            is_repeat_q <= is_repeat_d;
            key_held_q  <= (state_d == HELD) || (state_d == REPEAT) || (state_d == RELEASE);
        end
    end

    assign strobe    = strobe_q;
    assign keycode   = keycode_q;
    assign key_held  = key_held_q;
    assign is_repeat = is_repeat_q;

endmodule
